// File: rtl/hazard_forward_unit.sv
// Hazard unit for a 5-stage RV32I pipeline. It does four things:
//   - selects EX-stage operand forwarding from MEM or WB;
//   - stalls for one cycle on a load-use hazard;
//   - freezes the pipe while an LSU/UART access is outstanding, with a watchdog;
//   - flushes IF/ID and ID/EX on a taken branch.
// A branch taken while frozen is remembered and flushes on the first unfrozen cycle.
module hazard_forward_unit #(
  parameter int REG_AW      = 5,
  parameter int LSU_TIMEOUT = 1024,
  parameter int FWD_WB_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_w,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_w,
  input  logic              lsu_req,
  input  logic              lsu_done,
  input  logic              br_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_fetch,
  output logic              bubble_ex,
  output logic              freeze,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              lsu_timeout
);

  localparam int CW = $clog2(LSU_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LSU_TIMEOUT - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [REG_AW-1:0] X0 = '0;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic          pending_flush, pending_nxt;
  logic          frz, tmo, fl, lu, lu_stall;
  logic [1:0]    fa, fb;

  // Operand source select; MEM holds the younger value, so it beats WB.
  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
    if (mem_reg_w && mem_rd != X0 && mem_rd == ex_rs1)
      fa = 2'b01;
    else if (FWD_WB_EN != 0 && wb_reg_w && wb_rd != X0 && wb_rd == ex_rs1)
      fa = 2'b10;
    if (mem_reg_w && mem_rd != X0 && mem_rd == ex_rs2)
      fb = 2'b01;
    else if (FWD_WB_EN != 0 && wb_reg_w && wb_rd != X0 && wb_rd == ex_rs2)
      fb = 2'b10;
  end

  // LSU wait FSM: freeze while the access is outstanding; the watchdog forces release.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    frz       = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (lsu_req && !lsu_done) begin
          frz       = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      S_WAIT: begin
        if (lsu_done) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (wait_cnt == CNT_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          frz     = 1'b1;
          cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Flush and load-use arbitration. Freeze wins over flush, and flush wins over stall.
  always_comb begin
    fl          = (br_taken || pending_flush) && !frz;
    lu          = ex_mem_read && ex_rd != X0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    lu_stall    = lu && !frz && !fl;
    pending_nxt = pending_flush;
    if (fl)
      pending_nxt = 1'b0;
    else if (br_taken && frz)
      pending_nxt = 1'b1;
  end

  // While reset is asserted, every output is forced low whatever the inputs are.
  always_comb begin
    fwd_a       = rst_n ? fa : 2'b00;
    fwd_b       = rst_n ? fb : 2'b00;
    freeze      = rst_n & frz;
    lsu_timeout = rst_n & tmo;
    flush_if_id = rst_n & fl;
    flush_id_ex = rst_n & fl;
    stall_fetch = rst_n & lu_stall;
    bubble_ex   = rst_n & lu_stall;
  end

  // State registers. A reset in the middle of a wait drops the access and any deferred flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      pending_flush <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= cnt_nxt;
      pending_flush <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit with a scoreboard.
// The driver pushes a hand-computed expectation for each cycle.
// The monitor pops it on the falling edge and compares.
module tb_hazard_forward_unit;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_reg_w;
    logic [4:0] wb_rd;
    logic       wb_reg_w, lsu_req, lsu_done, br_taken;
  } in_t;

  // fa2 is operand A from the second instance, which is built with WB forwarding disabled.
  typedef struct packed {
    logic [1:0] fa, fb;
    logic       stall, bubble, frz, fif, fie, tmo;
    logic [1:0] fa2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  vin = '0;

  logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic stall_fetch, bubble_ex, freeze, flush_if_id, flush_id_ex, lsu_timeout;
  logic st2, bu2, fr2, fi2, fe2, to2;

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(5), .LSU_TIMEOUT(8), .FWD_WB_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(vin.id_rs1), .id_rs2(vin.id_rs2), .ex_rs1(vin.ex_rs1), .ex_rs2(vin.ex_rs2),
    .ex_rd(vin.ex_rd), .ex_mem_read(vin.ex_mem_read), .mem_rd(vin.mem_rd),
    .mem_reg_w(vin.mem_reg_w), .wb_rd(vin.wb_rd), .wb_reg_w(vin.wb_reg_w),
    .lsu_req(vin.lsu_req), .lsu_done(vin.lsu_done), .br_taken(vin.br_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_fetch(stall_fetch), .bubble_ex(bubble_ex),
    .freeze(freeze), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .lsu_timeout(lsu_timeout)
  );

  hazard_forward_unit #(.REG_AW(5), .LSU_TIMEOUT(8), .FWD_WB_EN(0)) dut_nowb (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(vin.id_rs1), .id_rs2(vin.id_rs2), .ex_rs1(vin.ex_rs1), .ex_rs2(vin.ex_rs2),
    .ex_rd(vin.ex_rd), .ex_mem_read(vin.ex_mem_read), .mem_rd(vin.mem_rd),
    .mem_reg_w(vin.mem_reg_w), .wb_rd(vin.wb_rd), .wb_reg_w(vin.wb_reg_w),
    .lsu_req(vin.lsu_req), .lsu_done(vin.lsu_done), .br_taken(vin.br_taken),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_fetch(st2), .bubble_ex(bu2),
    .freeze(fr2), .flush_if_id(fi2), .flush_id_ex(fe2), .lsu_timeout(to2)
  );

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                              input logic frz, input logic fl, input logic tmo,
                              input logic [1:0] fa2);
    exp_t e;
    e.fa = fa; e.fb = fb; e.stall = st; e.bubble = st; e.frz = frz;
    e.fif = fl; e.fie = fl; e.tmo = tmo; e.fa2 = fa2;
    return e;
  endfunction

  // Apply one cycle of stimulus just after the rising edge and queue what it should produce.
  task automatic drive(input logic r, input in_t v, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n = r;
    vin   = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the queued expectation on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.fa = fwd_a; a.fb = fwd_b; a.stall = stall_fetch; a.bubble = bubble_ex;
      a.frz = freeze; a.fif = flush_if_id; a.fie = flush_id_ex; a.tmo = lsu_timeout;
      a.fa2 = fwd_a2;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got fa=%b fb=%b st=%b bu=%b frz=%b fif=%b fie=%b tmo=%b fa2=%b, want fa=%b fb=%b st=%b bu=%b frz=%b fif=%b fie=%b tmo=%b fa2=%b",
                 nm, a.fa, a.fb, a.stall, a.bubble, a.frz, a.fif, a.fie, a.tmo, a.fa2,
                 e.fa, e.fb, e.stall, e.bubble, e.frz, e.fif, e.fie, e.tmo, e.fa2);
      end
    end
  end

  initial begin
    in_t v;
    int  guard;
    // While reset is held, noisy inputs must not reach any output.
    v = '0; v.lsu_req = 1; v.br_taken = 1; v.ex_rs1 = 5; v.mem_rd = 5; v.mem_reg_w = 1;
    v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs1 = 7;
    drive(0, v, mk(0, 0, 0, 0, 0, 0, 0), "reset_outputs");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "idle_after_reset");

    // Forwarding.
    v = '0; v.ex_rs1 = 5; v.mem_rd = 5; v.mem_reg_w = 1; v.wb_rd = 5; v.wb_reg_w = 1;
    drive(1, v, mk(2'b01, 0, 0, 0, 0, 0, 2'b01), "fwd_mem_over_wb");
    v.mem_reg_w = 0;
    drive(1, v, mk(2'b10, 0, 0, 0, 0, 0, 2'b00), "fwd_wb_only");
    v.mem_reg_w = 1; v.ex_rs1 = 0; v.ex_rs2 = 5;
    drive(1, v, mk(2'b00, 2'b01, 0, 0, 0, 0, 2'b00), "fwd_x0_and_b_mem");
    v = '0; v.ex_rs1 = 3; v.ex_rs2 = 4; v.mem_rd = 3; v.mem_reg_w = 1; v.wb_rd = 4; v.wb_reg_w = 1;
    drive(1, v, mk(2'b01, 2'b10, 0, 0, 0, 0, 2'b01), "fwd_split_a_mem_b_wb");

    // Load-use.
    v = '0; v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs2 = 7;
    drive(1, v, mk(0, 0, 1, 0, 0, 0, 0), "loaduse_stall");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "loaduse_one_cycle");
    v.ex_rd = 0;
    drive(1, v, mk(0, 0, 0, 0, 0, 0, 0), "loaduse_x0_no_stall");

    // A 4-cycle freeze. The branch taken while frozen is deferred, and a load-use is masked.
    v = '0; v.lsu_req = 1;
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "lsu_freeze_c0");
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "lsu_freeze_c1");
    v.br_taken = 1;
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "lsu_freeze_br_held");
    v.br_taken = 0; v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs1 = 7;
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "lsu_freeze_masks_lu");
    v = '0; v.lsu_req = 1; v.lsu_done = 1;
    drive(1, v, mk(0, 0, 0, 0, 1, 0, 0), "lsu_done_deferred_flush");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "pending_cleared");
    drive(1, v, mk(0, 0, 0, 0, 0, 0, 0), "lsu_single_cycle");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "idle_after_single");

    // Watchdog with LSU_TIMEOUT=8: the freeze lasts 7 cycles, then a timeout pulse.
    v = '0; v.lsu_req = 1;
    for (int i = 0; i < 7; i++) drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "timeout_freeze");
    drive(1, '0, mk(0, 0, 0, 0, 0, 1, 0), "timeout_pulse");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "timeout_pulse_ends");

    // A done arriving in the watchdog's last cycle takes priority and produces no pulse.
    for (int i = 0; i < 7; i++) drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "done_vs_timeout_freeze");
    v.lsu_done = 1;
    drive(1, v, mk(0, 0, 0, 0, 0, 0, 0), "done_beats_timeout");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "idle_after_done");

    // Flush together with a load-use: the flush wins and there is no stall.
    v = '0; v.br_taken = 1; v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs1 = 7;
    drive(1, v, mk(0, 0, 0, 0, 1, 0, 0), "flush_over_loaduse");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "flush_one_cycle");

    // Reset in the middle of a wait (cnt=3, pending_flush=1).
    v = '0; v.lsu_req = 1;
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "rstwait_c0");
    v.br_taken = 1;
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "rstwait_c1_br");
    v.br_taken = 0;
    drive(1, v, mk(0, 0, 0, 1, 0, 0, 0), "rstwait_c2");
    drive(0, v, mk(0, 0, 0, 0, 0, 0, 0), "rst_midwait_outputs");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "post_rst_idle_no_flush");
    drive(1, '0, mk(0, 0, 0, 0, 0, 0, 0), "post_rst_idle2");

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
